bram_arbiter: RTL

- Two-master to one-slave arbiter directly upstream of the block RAM.
- Merges the core's instruction port (imem) and data port (dmem) onto the single bram request interface.
- Buffers one request per master, arbitrates round-robin and keeps one bram transaction in flight.
- Returns read data and ready to the owning master.

---
 rtl/bram_arbiter_pkg.sv | 42 ++++
 rtl/bram_arbiter_chk.sv | 46 ++++
 rtl/bram_arbiter_slot.sv | 55 +++++
 rtl/bram_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bram_arbiter_pkg.sv
// Shared types, constants and grant helper for the two-master BRAM arbiter.
package bram_arbiter_pkg;

    // Default log2 of the BRAM word count; only the checker uses it.
    localparam int BRAM_DEPTH_DEF = 10;

    // Encoding of the round-robin pointer.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // One buffered memory request; wstrb == 0 denotes a read.
    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } arb_state_t;

    // Pick the slot to issue: the only pending one, or the one opposite the last grant.
    function automatic logic pick_grant(
        input logic pend_i,
        input logic pend_d,
        input logic last_grant
    );
        logic grant_v;
        if (pend_i && pend_d) begin
            grant_v = ~last_grant;
        end else if (pend_d) begin
            grant_v = GRANT_D;
        end else begin
            grant_v = GRANT_I;
        end
        return grant_v;
    endfunction

endpackage

// File: rtl/bram_arbiter_chk.sv
// Protocol checker for the arbiter: dropped requests, ready exclusivity, pulse width, address range.
module bram_arbiter_chk #(
    parameter int BRAM_DEPTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_valid,
    input  logic        imem_pend,
    input  logic        dmem_valid,
    input  logic        dmem_pend,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        bram_valid,
    input  logic [31:0] bram_addr
);

    localparam logic [33:0] BRAM_BYTES = 34'd1 << (BRAM_DEPTH + 2);

    logic r_prev_bram_valid;

    // Remember last cycle's bram_valid to confirm the request is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_bram_valid <= 1'b0;
        end else begin
            r_prev_bram_valid <= bram_valid;
        end
    end

    // Check the master/BRAM handshake rules on every active edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(imem_valid && imem_pend))
                else $warning("imem request dropped: slot still pending");
            assert (!(dmem_valid && dmem_pend))
                else $warning("dmem request dropped: slot still pending");
            assert (!(imem_ready && dmem_ready))
                else $error("imem_ready and dmem_ready high together");
            assert (!(bram_valid && r_prev_bram_valid))
                else $error("bram_valid held longer than one cycle");
            assert (!bram_valid || ({2'b00, bram_addr} < BRAM_BYTES))
                else $error("bram_addr 0x%08h outside BRAM", bram_addr);
        end
    end

endmodule

// File: rtl/bram_arbiter_slot.sv
// Per-master slot: one-deep request buffer, pending flag and response registers.
module bram_arbiter_slot
    import bram_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  mem_req_t    i_req,
    input  logic        i_rsp,
    input  logic [31:0] i_rsp_data,
    output logic        o_pend,
    output mem_req_t    o_req,
    output logic [31:0] o_rdata,
    output logic        o_ready
);

    logic        r_pend;
    mem_req_t    r_req;
    logic [31:0] r_rdata;
    logic        r_ready;

    // Capture a new request into an empty slot; a request hitting a full slot is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
            r_req  <= '0;
        end else if (i_valid && !r_pend) begin
            r_pend <= 1'b1;
            r_req  <= i_req;
        end else if (i_rsp) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= r_pend;
        end
    end

    // Register the BRAM response for the owning master; rdata holds until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'h0000_0000;
            r_ready <= 1'b0;
        end else if (i_rsp) begin
            r_rdata <= i_rsp_data;
            r_ready <= 1'b1;
        end else begin
            r_ready <= 1'b0;
        end
    end

    assign o_pend  = r_pend;
    assign o_req   = r_req;
    assign o_rdata = r_rdata;
    assign o_ready = r_ready;

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter merging the instruction and data ports onto one BRAM port.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int BRAM_DEPTH = BRAM_DEPTH_DEF
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        imem_valid,
    input  logic        imem_instr,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic        dmem_instr,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        bram_valid,
    output logic        bram_instr,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic [31:0] bram_rdata,
    input  logic        bram_ready
);

    arb_state_t r_state;
    arb_state_t w_nxt_state;
    logic       r_last_grant;
    logic       r_bram_valid;
    mem_req_t   r_bram_req;

    mem_req_t   w_in_req_i;
    mem_req_t   w_in_req_d;
    mem_req_t   w_req_i;
    mem_req_t   w_req_d;
    mem_req_t   w_issue_req;
    logic       w_pend_i;
    logic       w_pend_d;
    logic       w_issue_i;
    logic       w_issue_d;
    logic       w_rsp_i;
    logic       w_rsp_d;

    assign w_in_req_i = {imem_instr, imem_addr, imem_wdata, imem_wstrb};
    assign w_in_req_d = {dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb};

    bram_arbiter_slot u_slot_i (
        .clk        (clk),
        .rst_n      (rst),
        .i_valid    (imem_valid),
        .i_req      (w_in_req_i),
        .i_rsp      (w_rsp_i),
        .i_rsp_data (bram_rdata),
        .o_pend     (w_pend_i),
        .o_req      (w_req_i),
        .o_rdata    (imem_rdata),
        .o_ready    (imem_ready)
    );

    bram_arbiter_slot u_slot_d (
        .clk        (clk),
        .rst_n      (rst),
        .i_valid    (dmem_valid),
        .i_req      (w_in_req_d),
        .i_rsp      (w_rsp_d),
        .i_rsp_data (bram_rdata),
        .o_pend     (w_pend_d),
        .o_req      (w_req_d),
        .o_rdata    (dmem_rdata),
        .o_ready    (dmem_ready)
    );

    // Next-state logic: issue from registered pending flags, retire on bram_ready in WAIT states.
    always_comb begin
        w_nxt_state = r_state;
        w_issue_i   = 1'b0;
        w_issue_d   = 1'b0;
        w_rsp_i     = 1'b0;
        w_rsp_d     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pend_i || w_pend_d) begin
                    if (pick_grant(w_pend_i, w_pend_d, r_last_grant) == GRANT_I) begin
                        w_issue_i   = 1'b1;
                        w_nxt_state = WAIT_I;
                    end else begin
                        w_issue_d   = 1'b1;
                        w_nxt_state = WAIT_D;
                    end
                end else begin
                    w_nxt_state = IDLE;
                end
            end
            WAIT_I: begin
                if (bram_ready) begin
                    w_rsp_i = 1'b1;
                    if (w_pend_d) begin
                        w_issue_d   = 1'b1;
                        w_nxt_state = WAIT_D;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end else begin
                    w_nxt_state = WAIT_I;
                end
            end
            WAIT_D: begin
                if (bram_ready) begin
                    w_rsp_d = 1'b1;
                    if (w_pend_i) begin
                        w_issue_i   = 1'b1;
                        w_nxt_state = WAIT_I;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end else begin
                    w_nxt_state = WAIT_D;
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    assign w_issue_req = w_issue_d ? w_req_d : w_req_i;

    // State register and round-robin pointer; the pointer follows every grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_D;
        end else begin
            r_state <= w_nxt_state;
            if (w_issue_i) begin
                r_last_grant <= GRANT_I;
            end else if (w_issue_d) begin
                r_last_grant <= GRANT_D;
            end else begin
                r_last_grant <= r_last_grant;
            end
        end
    end

    // Registered BRAM request: valid pulses for the issue cycle only, fields hold between issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bram_valid <= 1'b0;
            r_bram_req   <= '0;
        end else if (w_issue_i || w_issue_d) begin
            r_bram_valid <= 1'b1;
            r_bram_req   <= w_issue_req;
        end else begin
            r_bram_valid <= 1'b0;
        end
    end

    assign bram_valid = r_bram_valid;
    assign bram_instr = r_bram_req.instr;
    assign bram_addr  = r_bram_req.addr;
    assign bram_wdata = r_bram_req.wdata;
    assign bram_wstrb = r_bram_req.wstrb;

    bram_arbiter_chk #(
        .BRAM_DEPTH (BRAM_DEPTH)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst),
        .imem_valid (imem_valid),
        .imem_pend  (w_pend_i),
        .dmem_valid (dmem_valid),
        .dmem_pend  (w_pend_d),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .bram_valid (r_bram_valid),
        .bram_addr  (r_bram_req.addr)
    );

endmodule
